// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared types and constants for the result/bypass pipeline
//
// Purpose : default data/register widths, the per-stage destination record
//           and the hard-wired zero register address.
// Ports   : none (package).

package rv_pipe_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int DEF_REG_AW = 5;

   // x0 is hard-wired: never forwarded, never written back.
   localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

   // One in-flight destination record. ready = 0 marks a load whose data
   // has not been merged yet.
   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic                  ready;
      logic [DEF_REG_AW-1:0] rd;
      logic [DEF_XLEN-1:0]   data;
   } pipe_rec_t;

endpackage

// File: rtl/bypass_match.sv
// rtl/bypass_match.sv - single-port priority forwarding match over all stages
//
// Purpose : scans the pipeline records youngest (stage 0) to oldest and
//           reports the first record that writes rs_addr.
// Ports   : recs    in   STAGES pipeline records
//           rs_addr in   REG_AW lookup address
//           hit     out  youngest match is ready, data valid
//           stall   out  youngest match still waits for load data
//           data    out  XLEN forwarded data (0 unless hit)

module bypass_match
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int REG_AW = DEF_REG_AW,
   parameter int STAGES = 3
) (
   input  pipe_rec_t         recs [STAGES],
   input  logic [REG_AW-1:0] rs_addr,
   output logic              hit,
   output logic              stall,
   output logic [XLEN-1:0]   data
);

   logic found;

   // Only the youngest match decides the result: an older ready copy must
   // not hide a younger load that has not returned yet.
   always_comb begin
      hit   = 1'b0;
      stall = 1'b0;
      data  = '0;
      found = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (!found && recs[k].valid && recs[k].we &&
             (recs[k].rd == rs_addr) && (rs_addr != REG_ZERO)) begin
            found = 1'b1;
            if (recs[k].ready) begin
               hit  = 1'b1;
               data = recs[k].data;
            end else begin
               stall = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bypass_pipe.sv
// rtl/bypass_pipe.sv - parametrised EX-to-WB result pipeline with priority forwarding
//
// Purpose : carries destination records from EX to writeback with per-stage
//           flush, global stall and late load-data merge; serves NREAD
//           forwarding lookups with a data-not-ready stall indication.
// Option  : BYPASS_PERF_CNT_EN adds saturating hit/stall counters and a
//           simulation check that no unready record leaves LATE_STAGE.
// Ports   : clk, rst_n                     clock, async active-low reset
//           stall_i                        hold every stage, drop in_*
//           flush_i[STAGES]                clear valid of stage k
//           in_valid/rd/we/ready/data_i    record entering stage 0
//           late_we_i, late_data_i         load data for LATE_STAGE
//           rs_addr_i[NREAD*REG_AW]        lookup addresses
//           fwd_hit_o, fwd_stall_o[NREAD]  lookup results
//           fwd_data_o[NREAD*XLEN]         forwarded data
//           wb_we_o, wb_rd_o, wb_data_o    register-file write
//           hit_cnt_o, stall_cnt_o         (BYPASS_PERF_CNT_EN only)

module bypass_pipe
   import rv_pipe_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int REG_AW     = DEF_REG_AW,
   parameter int STAGES     = 3,
   parameter int NREAD      = 2,
   parameter int LATE_STAGE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall_i,
   input  logic [STAGES-1:0]       flush_i,
   input  logic                    in_valid_i,
   input  logic [REG_AW-1:0]       in_rd_i,
   input  logic                    in_we_i,
   input  logic                    in_ready_i,
   input  logic [XLEN-1:0]         in_data_i,
   input  logic                    late_we_i,
   input  logic [XLEN-1:0]         late_data_i,
   input  logic [NREAD*REG_AW-1:0] rs_addr_i,
   output logic [NREAD-1:0]        fwd_hit_o,
   output logic [NREAD-1:0]        fwd_stall_o,
   output logic [NREAD*XLEN-1:0]   fwd_data_o,
`ifdef BYPASS_PERF_CNT_EN
   output logic [31:0]             hit_cnt_o,
   output logic [31:0]             stall_cnt_o,
`endif
   output logic                    wb_we_o,
   output logic [REG_AW-1:0]       wb_rd_o,
   output logic [XLEN-1:0]         wb_data_o
);

   pipe_rec_t stage_q [STAGES];
   pipe_rec_t stage_d [STAGES];
   pipe_rec_t in_rec;

   always_comb begin
      in_rec       = '0;
      in_rec.valid = in_valid_i;
      in_rec.we    = in_we_i;
      in_rec.ready = in_ready_i;
      in_rec.rd    = in_rd_i;
      in_rec.data  = in_data_i;
   end

   // Next-state: shift or hold, then late merge, then flush. Flush is applied
   // last so it wins over both the shift and the merge for its stage.
   always_comb begin
      stage_d[0] = stall_i ? stage_q[0] : in_rec;
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k] = stall_i ? stage_q[k] : stage_q[k-1];
      end

      // On a shift this is the record arriving in LATE_STAGE; on stall it is
      // the record already parked there.
      if (late_we_i && stage_d[LATE_STAGE].valid && !stage_d[LATE_STAGE].ready) begin
         stage_d[LATE_STAGE].data  = late_data_i;
         stage_d[LATE_STAGE].ready = 1'b1;
      end

      for (int k = 0; k < STAGES; k++) begin
         if (flush_i[k]) begin
            stage_d[k].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   // Writeback is taken straight from the last stage register.
   assign wb_we_o   = stage_q[STAGES-1].valid && stage_q[STAGES-1].we &&
                      (stage_q[STAGES-1].rd != REG_ZERO);
   assign wb_rd_o   = stage_q[STAGES-1].rd;
   assign wb_data_o = stage_q[STAGES-1].data;

   for (genvar p = 0; p < NREAD; p++) begin : g_port
      bypass_match #(
         .XLEN   (XLEN),
         .REG_AW (REG_AW),
         .STAGES (STAGES)
      ) u_match (
         .recs    (stage_q),
         .rs_addr (rs_addr_i[p*REG_AW +: REG_AW]),
         .hit     (fwd_hit_o[p]),
         .stall   (fwd_stall_o[p]),
         .data    (fwd_data_o[p*XLEN +: XLEN])
      );
   end

`ifdef BYPASS_PERF_CNT_EN
   // One spare bit catches the wrap so the counters can pin at all-ones.
   logic [32:0] hit_sum;
   logic [32:0] stall_sum;

   always_comb begin
      hit_sum   = {1'b0, hit_cnt_o};
      stall_sum = {1'b0, stall_cnt_o};
      for (int p = 0; p < NREAD; p++) begin
         hit_sum   = hit_sum   + 33'(fwd_hit_o[p]);
         stall_sum = stall_sum + 33'(fwd_stall_o[p]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_o   <= '0;
         stall_cnt_o <= '0;
      end else begin
         hit_cnt_o   <= hit_sum[32]   ? '1 : hit_sum[31:0];
         stall_cnt_o <= stall_sum[32] ? '1 : stall_sum[31:0];
      end
   end

   // A record still waiting for load data must not move past LATE_STAGE;
   // a flush of the destination stage discards it and is harmless.
   late_ready_chk : assert property (@(posedge clk) disable iff (!rst_n)
      !(!stall_i && stage_q[LATE_STAGE].valid && !stage_q[LATE_STAGE].ready &&
        !flush_i[LATE_STAGE+1]));
`endif

endmodule

// File: tb/tb_bypass_pipe.sv
// tb/tb_bypass_pipe.sv - self-checking bench for bypass_pipe

module tb_bypass_pipe;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int STAGES     = 3;
   localparam int NREAD      = 2;
   localparam int LATE_STAGE = 1;

   logic                    clk;
   logic                    rst_n;
   logic                    stall_i;
   logic [STAGES-1:0]       flush_i;
   logic                    in_valid_i;
   logic [REG_AW-1:0]       in_rd_i;
   logic                    in_we_i;
   logic                    in_ready_i;
   logic [XLEN-1:0]         in_data_i;
   logic                    late_we_i;
   logic [XLEN-1:0]         late_data_i;
   logic [NREAD*REG_AW-1:0] rs_addr_i;
   logic [NREAD-1:0]        fwd_hit_o;
   logic [NREAD-1:0]        fwd_stall_o;
   logic [NREAD*XLEN-1:0]   fwd_data_o;
   logic                    wb_we_o;
   logic [REG_AW-1:0]       wb_rd_o;
   logic [XLEN-1:0]         wb_data_o;
`ifdef BYPASS_PERF_CNT_EN
   logic [31:0]             hit_cnt_o;
   logic [31:0]             stall_cnt_o;
`endif

   int total_cnt = 0;
   int pass_cnt  = 0;

   bypass_pipe #(
      .XLEN       (XLEN),
      .REG_AW     (REG_AW),
      .STAGES     (STAGES),
      .NREAD      (NREAD),
      .LATE_STAGE (LATE_STAGE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_rd_i     (in_rd_i),
      .in_we_i     (in_we_i),
      .in_ready_i  (in_ready_i),
      .in_data_i   (in_data_i),
      .late_we_i   (late_we_i),
      .late_data_i (late_data_i),
      .rs_addr_i   (rs_addr_i),
      .fwd_hit_o   (fwd_hit_o),
      .fwd_stall_o (fwd_stall_o),
      .fwd_data_o  (fwd_data_o),
`ifdef BYPASS_PERF_CNT_EN
      .hit_cnt_o   (hit_cnt_o),
      .stall_cnt_o (stall_cnt_o),
`endif
      .wb_we_o     (wb_we_o),
      .wb_rd_o     (wb_rd_o),
      .wb_data_o   (wb_data_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- reference model: a queue, index 0 = youngest ----------
   typedef struct {
      bit          v;
      bit          we;
      bit          rdy;
      logic [4:0]  rd;
      logic [31:0] data;
   } m_rec_t;

   m_rec_t pipe[$];

   task automatic model_reset();
      m_rec_t z;
      z.v = 0; z.we = 0; z.rdy = 0; z.rd = '0; z.data = '0;
      pipe.delete();
      for (int i = 0; i < STAGES; i++) pipe.push_back(z);
   endtask

   task automatic model_step();
      m_rec_t r;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!stall_i) begin
            r.v = in_valid_i; r.we = in_we_i; r.rdy = in_ready_i;
            r.rd = in_rd_i; r.data = in_data_i;
            pipe.push_front(r);
            void'(pipe.pop_back());
         end
         r = pipe[LATE_STAGE];
         if (late_we_i && r.v && !r.rdy) begin
            r.data = late_data_i;
            r.rdy  = 1;
            pipe[LATE_STAGE] = r;
         end
         for (int k = 0; k < STAGES; k++) begin
            if (flush_i[k]) begin
               r = pipe[k];
               r.v = 0;
               pipe[k] = r;
            end
         end
      end
   endtask

   task automatic model_lookup(input logic [4:0] rs, output bit h, output bit s,
                               output logic [31:0] d);
      h = 0; s = 0; d = '0;
      if (rs != 0) begin
         foreach (pipe[k]) begin
            if (!h && !s && pipe[k].v && pipe[k].we && pipe[k].rd == rs) begin
               if (pipe[k].rdy) begin h = 1; d = pipe[k].data; end
               else s = 1;
            end
         end
      end
   endtask

   // ---------------- checking helpers --------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_fwd(input int p, input bit eh, input bit es,
                            input logic [31:0] ed, input string tag);
      chk($sformatf("%s p%0d hit", tag, p), 32'(fwd_hit_o[p]), 32'(eh));
      chk($sformatf("%s p%0d stall", tag, p), 32'(fwd_stall_o[p]), 32'(es));
      if (!es) chk($sformatf("%s p%0d data", tag, p), fwd_data_o[p*XLEN +: XLEN], ed);
   endtask

   task automatic check_wb(input bit ewe, input logic [4:0] erd,
                           input logic [31:0] edata, input string tag);
      chk({tag, " wb_we"}, 32'(wb_we_o), 32'(ewe));
      chk({tag, " wb_rd"}, 32'(wb_rd_o), 32'(erd));
      chk({tag, " wb_data"}, wb_data_o, edata);
   endtask

   task automatic compare_model(input string tag);
      bit h, s;
      logic [31:0] d;
      for (int p = 0; p < NREAD; p++) begin
         model_lookup(rs_addr_i[p*REG_AW +: REG_AW], h, s, d);
         check_fwd(p, h, s, d, tag);
      end
      check_wb(pipe[STAGES-1].v && pipe[STAGES-1].we && pipe[STAGES-1].rd != 0,
               pipe[STAGES-1].rd, pipe[STAGES-1].data, tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input bit v, input logic [4:0] rd, input bit we,
                         input bit rdy, input logic [31:0] data);
      in_valid_i = v; in_rd_i = rd; in_we_i = we; in_ready_i = rdy; in_data_i = data;
   endtask

   // ---------------- directed vector table ---------------------------------
   typedef struct {
      bit          iv;
      logic [4:0]  ird;
      bit          iwe;
      bit          irdy;
      logic [31:0] idata;
      bit          stall;
      logic [2:0]  flush;
      bit          lwe;
      logic [31:0] ldata;
      logic [4:0]  rs0;
      logic [4:0]  rs1;
      bit          h0;
      bit          s0;
      logic [31:0] d0;
      bit          h1;
      bit          s1;
      logic [31:0] d1;
      bit          wwe;
      logic [4:0]  wrd;
      logic [31:0] wdata;
   } vec_t;

   function automatic vec_t mk(bit iv, logic [4:0] ird, bit iwe, bit irdy, logic [31:0] idata,
                               bit stall, logic [2:0] flush, bit lwe, logic [31:0] ldata,
                               logic [4:0] rs0, logic [4:0] rs1,
                               bit h0, bit s0, logic [31:0] d0,
                               bit h1, bit s1, logic [31:0] d1,
                               bit wwe, logic [4:0] wrd, logic [31:0] wdata);
      vec_t v;
      v.iv = iv; v.ird = ird; v.iwe = iwe; v.irdy = irdy; v.idata = idata;
      v.stall = stall; v.flush = flush; v.lwe = lwe; v.ldata = ldata;
      v.rs0 = rs0; v.rs1 = rs1;
      v.h0 = h0; v.s0 = s0; v.d0 = d0; v.h1 = h1; v.s1 = s1; v.d1 = d1;
      v.wwe = wwe; v.wrd = wrd; v.wdata = wdata;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      rst_n = 1'b0;
      stall_i = 1'b0; flush_i = '0;
      set_in(0, 0, 0, 0, 0);
      late_we_i = 1'b0; late_data_i = '0; rs_addr_i = '0;
      model_reset();

      //         in: v rd we rdy data    stall flush  late      rs0 rs1  port0          port1          wb
      tbl.push_back(mk(1,5,1,1,32'h11,   0,3'b000, 0,0,         5,0,  1,0,32'h11,    0,0,0,         0,0,0));
      tbl.push_back(mk(1,5,1,1,32'h22,   0,3'b000, 0,0,         5,6,  1,0,32'h22,    0,0,0,         0,0,0));
      tbl.push_back(mk(1,0,1,1,32'hFFFF, 0,3'b000, 0,0,         0,5,  0,0,0,         1,0,32'h22,    1,5,32'h11));
      tbl.push_back(mk(0,0,0,0,0,        0,3'b000, 0,0,         5,0,  1,0,32'h22,    0,0,0,         1,5,32'h22));
      tbl.push_back(mk(0,0,0,0,0,        0,3'b000, 0,0,         0,0,  0,0,0,         0,0,0,         0,0,32'hFFFF));
      tbl.push_back(mk(1,7,1,0,32'h5,    0,3'b000, 0,0,         7,7,  0,1,0,         0,1,0,         0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,3'b000, 1,32'hDEAD,  7,7,  1,0,32'hDEAD,  1,0,32'hDEAD,  0,0,0));
      tbl.push_back(mk(1,9,1,1,32'h99,   0,3'b000, 0,0,         7,9,  1,0,32'hDEAD,  1,0,32'h99,    1,7,32'hDEAD));
      tbl.push_back(mk(1,9,1,0,0,        0,3'b000, 0,0,         9,9,  0,1,0,         0,1,0,         0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,3'b000, 1,32'hBEEF,  9,9,  1,0,32'hBEEF,  1,0,32'hBEEF,  1,9,32'h99));
      tbl.push_back(mk(1,3,1,1,32'h33,   1,3'b010, 0,0,         9,3,  1,0,32'h99,    0,0,0,         1,9,32'h99));
      tbl.push_back(mk(1,3,1,1,32'h33,   1,3'b010, 0,0,         9,3,  1,0,32'h99,    0,0,0,         1,9,32'h99));
      tbl.push_back(mk(1,3,1,1,32'h33,   0,3'b000, 0,0,         3,9,  1,0,32'h33,    0,0,0,         0,9,32'hBEEF));
      tbl.push_back(mk(1,4,1,1,32'h44,   0,3'b001, 0,0,         4,3,  0,0,0,         1,0,32'h33,    0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,3'b000, 1,32'hBAD,   3,4,  1,0,32'h33,    0,0,0,         1,3,32'h33));

      // reset state
      tick(); tick();
      check_wb(0, 0, 0, "reset");
      chk("reset fwd_hit", 32'(fwd_hit_o), 32'h0);
      chk("reset fwd_stall", 32'(fwd_stall_o), 32'h0);
      chk("reset fwd_data nonzero", 32'(fwd_data_o != '0), 32'h0);
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].iv, tbl[i].ird, tbl[i].iwe, tbl[i].irdy, tbl[i].idata);
         stall_i = tbl[i].stall; flush_i = tbl[i].flush;
         late_we_i = tbl[i].lwe; late_data_i = tbl[i].ldata;
         rs_addr_i = {tbl[i].rs1, tbl[i].rs0};
         tick();
         check_fwd(0, tbl[i].h0, tbl[i].s0, tbl[i].d0, $sformatf("row%0d", i));
         check_fwd(1, tbl[i].h1, tbl[i].s1, tbl[i].d1, $sformatf("row%0d", i));
         check_wb(tbl[i].wwe, tbl[i].wrd, tbl[i].wdata, $sformatf("row%0d", i));
      end

      // reset in the middle of a full pipeline
      stall_i = 0; flush_i = '0; late_we_i = 0;
      set_in(1, 2, 1, 1, 32'h2A);
      rs_addr_i = {5'd2, 5'd2};
      tick(); tick(); tick();
      chk("full wb_we", 32'(wb_we_o), 32'h1);
      chk("full fwd_hit", 32'(fwd_hit_o), 32'h3);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async rst wb_we", 32'(wb_we_o), 32'h0);
      chk("async rst fwd_hit", 32'(fwd_hit_o), 32'h0);
      tick();
      rst_n = 1'b1;
      set_in(1, 6, 1, 1, 32'h66);
      rs_addr_i = '0;
      tick();
      chk("post-rst e1 wb_we", 32'(wb_we_o), 32'h0);
      set_in(0, 0, 0, 0, 0);
      tick();
      chk("post-rst e2 wb_we", 32'(wb_we_o), 32'h0);
      tick();
      check_wb(1, 6, 32'h66, "post-rst e3");

      // randomized stimulus against the queue model
      for (int n = 0; n < 1500; n++) begin
         set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, $urandom);
         stall_i = ($urandom_range(0, 4) == 0);
         flush_i = '0;
         for (int k = 0; k < STAGES; k++) flush_i[k] = ($urandom_range(0, 9) == 0);
`ifdef BYPASS_PERF_CNT_EN
         late_we_i = 1'b1;
`else
         late_we_i = $urandom_range(0, 1) != 0;
`endif
         late_data_i = $urandom;
         rs_addr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         tick();
         compare_model("rnd");
      end

`ifdef BYPASS_PERF_CNT_EN
      rst_n = 1'b0;
      stall_i = 0; flush_i = '0; late_we_i = 0; rs_addr_i = '0;
      set_in(0, 0, 0, 0, 0);
      model_reset();
      tick();
      rst_n = 1'b1;
      chk("perf rst hit_cnt", hit_cnt_o, 32'h0);
      chk("perf rst stall_cnt", stall_cnt_o, 32'h0);
      set_in(1, 1, 1, 1, 32'h1);
      tick();
      set_in(0, 0, 0, 0, 0);
      stall_i = 1'b1;
      rs_addr_i = {5'd1, 5'd1};
      repeat (4) tick();
      rs_addr_i = '0;
      stall_i = 1'b0;
      chk("perf hit_cnt", hit_cnt_o, 32'd8);
      chk("perf stall_cnt", stall_cnt_o, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
